// File: rtl/dmem_arbiter.sv
// Shares one data memory between MEM-stage port A and loader port B, with lock and range trap.
// GNT is same-cycle, ACK/ERR/RDATA one cycle later; a losing requester holds REQ until GNT.

module dmem_arbiter #(
  parameter int DEPTH    = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic        A_LOCK,
  input  logic [63:0] A_ADDR,
  input  logic [63:0] A_WDATA,
  output logic        A_GNT,
  output logic        A_ACK,
  output logic        A_ERR,
  output logic [63:0] A_RDATA,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic        B_LOCK,
  input  logic [63:0] B_ADDR,
  input  logic [63:0] B_WDATA,
  output logic        B_GNT,
  output logic        B_ACK,
  output logic        B_ERR,
  output logic [63:0] B_RDATA,
  output logic        MEM_WRITE,
  output logic        MEM_READ,
  output logic [63:0] MEM_ADDR_IN,
  output logic [63:0] WRITE_DATA,
  input  logic [63:0] DATA_OUT
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t        state;
  logic          last_b;
  logic [CW-1:0] lcnt;
  logic [CW-1:0] lcnt_inc;
  logic          a_oor, b_oor;
  logic          any_gnt, sel_we, sel_lock, sel_oor, other_req;
  logic [63:0]   sel_addr, sel_wdata;

  assign a_oor    = A_ADDR >= 64'(DEPTH);
  assign b_oor    = B_ADDR >= 64'(DEPTH);
  assign lcnt_inc = lcnt + 1'b1;

  always_comb begin
    A_GNT = 1'b0;
    B_GNT = 1'b0;
    if (RESET_N) begin
      case (state)
        IDLE: begin
          if (A_REQ && B_REQ) begin
            A_GNT = last_b;
            B_GNT = !last_b;
          end else begin
            A_GNT = A_REQ;
            B_GNT = B_REQ;
          end
        end
        LOCK_A:  A_GNT = A_REQ;
        LOCK_B:  B_GNT = B_REQ;
        default: ;
      endcase
    end
  end

  always_comb begin
    any_gnt   = A_GNT | B_GNT;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_oor   = 1'b0;
    other_req = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (A_GNT) begin
      sel_we    = A_WE;
      sel_lock  = A_LOCK;
      sel_oor   = a_oor;
      other_req = B_REQ;
      sel_addr  = A_ADDR;
      sel_wdata = A_WDATA;
    end else if (B_GNT) begin
      sel_we    = B_WE;
      sel_lock  = B_LOCK;
      sel_oor   = b_oor;
      other_req = A_REQ;
      sel_addr  = B_ADDR;
      sel_wdata = B_WDATA;
    end
  end

  // A trapped address still consumes the slot but never strobes the memory.
  assign MEM_WRITE   = any_gnt & sel_we & ~sel_oor;
  assign MEM_READ    = any_gnt & ~sel_we & ~sel_oor;
  assign MEM_ADDR_IN = sel_addr;
  assign WRITE_DATA  = sel_wdata;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      A_ACK   <= 1'b0;
      A_ERR   <= 1'b0;
      A_RDATA <= '0;
      B_ACK   <= 1'b0;
      B_ERR   <= 1'b0;
      B_RDATA <= '0;
    end else begin
      A_ACK <= A_GNT;
      A_ERR <= A_GNT & a_oor;
      B_ACK <= B_GNT;
      B_ERR <= B_GNT & b_oor;
      if (A_GNT) begin
        if (a_oor)      A_RDATA <= '0;
        else if (!A_WE) A_RDATA <= DATA_OUT;
      end
      if (B_GNT) begin
        if (b_oor)      B_RDATA <= '0;
        else if (!B_WE) B_RDATA <= DATA_OUT;
      end
    end
  end

  // lcnt counts locked grants while the other port waits; hitting LOCK_MAX
  // drops back to IDLE, where LAST already points away from the owner.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      last_b <= 1'b1;
      lcnt   <= '0;
    end else if (any_gnt) begin
      last_b <= B_GNT;
      if (!sel_lock) begin
        state <= IDLE;
        lcnt  <= '0;
      end else if (other_req && (lcnt_inc >= CW'(LOCK_MAX))) begin
        state <= IDLE;
        lcnt  <= '0;
      end else begin
        state <= A_GNT ? LOCK_A : LOCK_B;
        if (other_req) lcnt <= lcnt_inc;
      end
    end else if (state != IDLE) begin
      state <= IDLE;
      lcnt  <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a per-access reference model.

module tb_dmem_arbiter;

  localparam int DEPTH    = 16;
  localparam int LOCK_MAX = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n;
  logic        req [2];
  logic        we [2];
  logic        lock [2];
  logic [63:0] addr [2];
  logic [63:0] wdata [2];

  logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
  logic [63:0] a_rdata, b_rdata;
  logic        mem_write, mem_read;
  logic [63:0] mem_addr, mem_wdata, data_out;

  logic [63:0] env_mem [16] = '{64'd5, 64'd3, 64'h102, 64'h103, 64'h104, 64'h105, 64'h106, 64'h107,
                                64'h108, 64'h109, 64'h10a, 64'h10b, 64'h10c, 64'h10d, 64'h10e, 64'h10f};
  logic [63:0] ref_mem [16] = '{64'd5, 64'd3, 64'h102, 64'h103, 64'h104, 64'h105, 64'h106, 64'h107,
                                64'h108, 64'h109, 64'h10a, 64'h10b, 64'h10c, 64'h10d, 64'h10e, 64'h10f};

  always @(posedge CLK) if (mem_write) env_mem[mem_addr[3:0]] <= mem_wdata;
  assign data_out = env_mem[mem_addr[3:0]];

  dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RESET_N(rst_n),
    .A_REQ(req[0]), .A_WE(we[0]), .A_LOCK(lock[0]), .A_ADDR(addr[0]), .A_WDATA(wdata[0]),
    .A_GNT(a_gnt), .A_ACK(a_ack), .A_ERR(a_err), .A_RDATA(a_rdata),
    .B_REQ(req[1]), .B_WE(we[1]), .B_LOCK(lock[1]), .B_ADDR(addr[1]), .B_WDATA(wdata[1]),
    .B_GNT(b_gnt), .B_ACK(b_ack), .B_ERR(b_err), .B_RDATA(b_rdata),
    .MEM_WRITE(mem_write), .MEM_READ(mem_read), .MEM_ADDR_IN(mem_addr),
    .WRITE_DATA(mem_wdata), .DATA_OUT(data_out)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: who owns the memory, who won last, how long the owner has held it.
  int          owner;
  int          last_win;
  int          run;
  int          last_grant;
  logic        exp_ack [2];
  logic        exp_err [2];
  logic [63:0] exp_rdata [2];
  logic        obs_ga, obs_gb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    owner    = -1;
    last_win = 1;
    run      = 0;
    for (int p = 0; p < 2; p++) begin
      exp_ack[p]   = 1'b0;
      exp_err[p]   = 1'b0;
      exp_rdata[p] = '0;
    end
  endtask

  function automatic int exp_winner();
    if (rst_n !== 1'b1) return -1;
    if (owner >= 0) return req[owner] ? owner : -1;
    if (req[0] && req[1]) return 1 - last_win;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_update(input int w);
    if (rst_n !== 1'b1) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++) begin
      exp_ack[p] = (w == p);
      exp_err[p] = (w == p) && (addr[p] >= DEPTH);
      if (w == p) begin
        if (addr[p] >= DEPTH) exp_rdata[p] = '0;
        else if (!we[p])      exp_rdata[p] = ref_mem[addr[p][3:0]];
      end
    end
    if (w < 0) begin
      owner = -1;
      run   = 0;
    end else begin
      if (we[w] && addr[w] < DEPTH) ref_mem[addr[w][3:0]] = wdata[w];
      last_win = w;
      if (!lock[w]) begin
        owner = -1;
        run   = 0;
      end else begin
        if (req[1-w]) run++;
        if (run >= LOCK_MAX) begin
          owner = -1;
          run   = 0;
        end else begin
          owner = w;
        end
      end
    end
  endtask

  // Called just after a rising edge with inputs set; checks this cycle, then advances one clock.
  task automatic cycle();
    int w;
    logic exp_wr, exp_rd;
    logic [63:0] exp_a, exp_d;
    #2;
    w = exp_winner();
    obs_ga = a_gnt;
    obs_gb = b_gnt;
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    if (w >= 0) begin
      exp_wr = we[w] && (addr[w] < DEPTH);
      exp_rd = !we[w] && (addr[w] < DEPTH);
      exp_a  = addr[w];
      exp_d  = wdata[w];
    end
    chk("a_gnt", 64'(a_gnt), 64'(w == 0));
    chk("b_gnt", 64'(b_gnt), 64'(w == 1));
    chk("mem_write", 64'(mem_write), 64'(exp_wr));
    chk("mem_read", 64'(mem_read), 64'(exp_rd));
    chk("mem_addr", mem_addr, exp_a);
    chk("mem_wdata", mem_wdata, exp_d);
    chk("a_ack", 64'(a_ack), 64'(exp_ack[0]));
    chk("b_ack", 64'(b_ack), 64'(exp_ack[1]));
    chk("a_err", 64'(a_err), 64'(exp_err[0]));
    chk("b_err", 64'(b_err), 64'(exp_err[1]));
    chk("a_rdata", a_rdata, exp_rdata[0]);
    chk("b_rdata", b_rdata, exp_rdata[1]);
    @(posedge CLK);
    model_update(w);
    last_grant = w;
    #1;
  endtask

  task automatic set_req(input int p, input logic r, input logic w, input logic l,
                         input logic [63:0] a, input logic [63:0] d);
    req[p]   = r;
    we[p]    = w;
    lock[p]  = l;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic rand_req(input int p);
    logic [63:0] a;
    a = ($urandom_range(0, 7) == 0) ? 64'(16 + $urandom_range(0, 100)) : 64'($urandom_range(0, 15));
    set_req(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
            a, {$urandom, $urandom});
  endtask

  initial begin
    logic [3:0] seq;
    int a_run;
    int diffs;
    logic seen_b;

    rst_n = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    last_grant = -1;
    model_reset();
    #1;

    // Reset with A already requesting: no grant, all responses zero.
    rst_n = 1'b0;
    set_req(0, 1, 0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Single read of word 0.
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    chk("t1_ack", 64'(a_ack), 64'd1);
    chk("t1_rdata", a_rdata, 64'd5);
    chk("t1_err", 64'(a_err), 64'd0);
    cycle();

    // Both ports streaming reads with no lock alternate A,B,A,B.
    do_reset();
    set_req(0, 1, 0, 0, 64'd2, 0);
    set_req(1, 1, 0, 0, 64'd3, 0);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq = {seq[2:0], obs_gb};
    end
    chk("alt_pattern", 64'(seq), 64'b0101);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    cycle();

    // Locked read-modify-write on word 1 while B waits for it.
    do_reset();
    set_req(0, 1, 0, 1, 64'd1, 0);
    set_req(1, 1, 0, 0, 64'd1, 0);
    cycle();
    chk("rmw_read", a_rdata, 64'd3);
    set_req(0, 1, 1, 0, 64'd1, 64'd8);
    cycle();
    chk("rmw_b_blocked", 64'(obs_gb), 64'd0);
    set_req(0, 0, 0, 0, 0, 0);
    cycle();
    set_req(1, 0, 0, 0, 0, 0);
    chk("rmw_b_rdata", b_rdata, 64'd8);
    cycle();

    // A holds lock continuously while B requests: LOCK_MAX grants, then B.
    do_reset();
    set_req(0, 1, 0, 1, 64'd4, 0);
    set_req(1, 1, 0, 0, 64'd5, 0);
    a_run  = 0;
    seen_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_gb) seen_b = 1'b1;
      if (obs_ga && !seen_b) a_run++;
    end
    chk("starve_run", 64'(a_run), 64'(LOCK_MAX));
    chk("starve_b_seen", 64'(seen_b), 64'd1);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    cycle();

    // Out-of-range write from B is acknowledged with an error and leaves memory alone.
    set_req(1, 1, 1, 0, 64'd16, 64'hFF);
    cycle();
    set_req(1, 0, 0, 0, 0, 0);
    chk("oor_ack", 64'(b_ack), 64'd1);
    chk("oor_err", 64'(b_err), 64'd1);
    cycle();
    diffs = 0;
    for (int i = 0; i < 16; i++) if (env_mem[i] !== ref_mem[i]) diffs++;
    chk("oor_mem_intact", 64'(diffs), 64'd0);

    // Asynchronous reset while A owns the lock with an ACK pending.
    do_reset();
    set_req(0, 1, 0, 1, 64'd2, 0);
    set_req(1, 1, 0, 0, 64'd3, 0);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_a_ack", 64'(a_ack), 64'd0);
    chk("arst_a_rdata", a_rdata, 64'd0);
    chk("arst_a_gnt", 64'(a_gnt), 64'd0);
    chk("arst_b_gnt", 64'(b_gnt), 64'd0);
    chk("arst_mem_read", 64'(mem_read), 64'd0);
    chk("arst_mem_write", 64'(mem_write), 64'd0);
    model_reset();
    set_req(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cycle();
    chk("arst_b_granted", 64'(obs_gb), 64'd1);
    set_req(1, 0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic; a port keeps its request stable until granted.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++)
        if (last_grant == p || !req[p]) rand_req(p);
      cycle();
    end
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    cycle();
    diffs = 0;
    for (int i = 0; i < 16; i++) if (env_mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem", 64'(diffs), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single data memory between two requesters: port A (pipeline MEM stage) and port B (loader/debug).
- Arbitration is round-robin per cycle. A requester may lock the memory for back-to-back atomic accesses, such as read-modify-write.
- Out-of-range addresses are trapped and return an error response instead of reaching the memory.
- Sits directly in front of the data memory and drives its write/read strobes, address and write data.

## Interface
Parameters:
- DEPTH, 16: number of 64-bit words in the data memory; valid word addresses are 0..DEPTH-1.
- LOCK_MAX, 4: maximum consecutive locked grants to one port while the other port is requesting.

Ports (each A_x/B_x line defines two identical ports, one per requester):
- CLK  input  1  system clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- A_REQ / B_REQ  input  1  access request; held with stable WE/ADDR/WDATA/LOCK until GNT.
- A_WE / B_WE  input  1  1 = write, 0 = read.
- A_LOCK / B_LOCK  input  1  keep ownership after this access.
- A_ADDR / B_ADDR  input  64  word address.
- A_WDATA / B_WDATA  input  64  write data.
- A_GNT / B_GNT  output  1  combinational; access accepted this cycle.
- A_ACK / B_ACK  output  1  registered one-cycle pulse, cycle after GNT.
- A_ERR / B_ERR  output  1  registered, valid with ACK; address out of range.
- A_RDATA / B_RDATA  output  64  registered read data, valid with ACK on a read.
- MEM_WRITE  output  1  memory write enable.
- MEM_READ  output  1  memory read enable.
- MEM_ADDR_IN  output  64  memory address.
- WRITE_DATA  output  64  memory write data.
- DATA_OUT  input  64  memory read data (combinational from address).

## Operation
- FSM states:
  - IDLE: round-robin between requesters.
  - LOCK_A: A owns the memory.
  - LOCK_B: B owns the memory.
- IDLE arbitration:
  - If only one port requests, that port wins.
  - If both request, the port not recorded in LAST wins.
  - LAST updates to the winner on every grant.
- LOCK_x state:
  - Only port x can win; the other port's requests wait.
- Transitions:
  - Grant to x with x_LOCK=1 → LOCK_x.
  - In LOCK_x, grant with x_LOCK=0 → IDLE.
  - In LOCK_x, a cycle with x_REQ=0 → IDLE (no grant).
- Fairness counter LCNT:
  - Counts grants made in LOCK_x while the other port requests.
  - When LCNT reaches LOCK_MAX, the next cycle is forced to IDLE and the other port wins.
  - LCNT clears on entry to IDLE.
- Winner path: winner's ADDR/WDATA drive MEM_ADDR_IN/WRITE_DATA; MEM_WRITE=WE, MEM_READ=~WE.
- With no winner, MEM_WRITE=MEM_READ=0 and address/data are 0.
- Range check: when ADDR >= DEPTH,
  - GNT is still given and the slot is consumed;
  - MEM_WRITE and MEM_READ stay 0;
  - the next cycle gives ACK=1, ERR=1, RDATA=0.
- Read: DATA_OUT is sampled into x_RDATA at the granting edge. On a write, RDATA holds its previous value.

## Timing
- Reset (RESET_N low, asynchronous):
  - state=IDLE, LAST=B (A wins the first tie), LCNT=0;
  - all ACK/ERR/RDATA = 0;
  - GNT, MEM_WRITE and MEM_READ are forced to 0 while reset is asserted.
- GNT: same cycle as REQ when that port wins (zero latency).
- ACK: exactly one cycle after GNT, for one cycle.
- Throughput: one access per cycle, sustained.
- Read data comes from memory state before the granting edge, so a write in cycle n is visible to a read granted in cycle n+1.
- Simultaneous requests: exactly one GNT per cycle; never both.
- Reset mid-transaction: pending ACKs are dropped and the lock is released.

## Test plan
- Reset then single read, memory[0]=5: A_REQ, A_ADDR=0, A_WE=0 → A_GNT same cycle, A_ACK next cycle with A_RDATA=5, A_ERR=0.
- Both ports request continuously, no lock, after reset → grants go A,B,A,B; each ACK follows its GNT by one cycle; never two GNTs in one cycle.
- A locked RMW: A reads addr 1 (value 3) with LOCK=1, then writes 8 with LOCK=0, while B requests throughout → B blocked for 2 cycles, then granted; a B read of addr 1 returns 8.
- Starvation guard, LOCK_MAX=4: A holds LOCK=1 and REQ=1 continuously while B requests → exactly 4 consecutive A grants, then B is granted.
- Out of range: B writes addr 16 with data 0xFF → B_GNT=1, MEM_WRITE stays 0, next cycle B_ACK=1 and B_ERR=1; memory is unchanged.
- Async reset while in LOCK_A with an ACK pending → all outputs 0 immediately; after release, a B request is granted with no A preference.
